// File: rtl/partybox_io_pkg.sv
// Shared widths, FSM state type and request payload for the IO bus arbiter.
package partybox_io_pkg;

  localparam int unsigned IO_ADDR_W = 16;
  localparam int unsigned IO_DATA_W = 16;
  localparam int unsigned IO_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } io_arb_state_e;

  // One requester's bus transaction as it is driven onto the IO bridge.
  typedef struct packed {
    logic                 rw;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_BE_W-1:0]   be;
    logic [IO_DATA_W-1:0] wdata;
  } io_req_t;

endpackage

// File: rtl/io_rr_picker.sv
// Round-robin picker: first valid requester at or after ptr+1 (mod NUM_REQ).
// Ports: valid (request vector), ptr (last granted index),
//        grant_c (one-hot), grant_idx_c (index), found_c (any valid).
module io_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               found_c
);

  int unsigned idx;

  // Scan the requesters in rotation order starting just after ptr.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found_c && valid[IDX_W'(idx)]) begin
        found_c                  = 1'b1;
        grant_c[IDX_W'(idx)]     = 1'b1;
        grant_idx_c              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one IO bus bridge between NUM_REQ requesters.
// Ports: clk_clk/reset_reset_n; req_* packed request inputs, req_ready
// (combinational accept); rsp_valid/rsp_rdata/rsp_err completion; busy;
// io_* bridge bus with io_acknowledge/io_read_data returning.
module io_bus_arbiter
  import partybox_io_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*IO_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*IO_BE_W-1:0]     req_be,
  input  logic [NUM_REQ*IO_DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [IO_DATA_W-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [IO_ADDR_W-1:0]           io_address,
  output logic                           io_bus_enable,
  output logic [IO_BE_W-1:0]             io_byte_enable,
  output logic                           io_rw,
  output logic [IO_DATA_W-1:0]           io_write_data,
  input  logic                           io_acknowledge,
  input  logic [IO_DATA_W-1:0]           io_read_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;

  io_arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   own_q, own_d;
  io_req_t              bus_q, bus_d;
  logic                 en_q, en_d;
  logic [NUM_REQ-1:0]   rsp_valid_d;
  logic [IO_DATA_W-1:0] rsp_rdata_d;
  logic                 rsp_err_d;

  logic [NUM_REQ-1:0]   grant_c;
  logic [IDX_W-1:0]     grant_idx_c;
  logic                 found_c;
  io_req_t              reqs [NUM_REQ];

  // Unpack the flat request buses into per-requester payloads.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqs[i] = '{rw:    req_rw[i],
                       addr:  req_addr[i*IO_ADDR_W +: IO_ADDR_W],
                       be:    req_be[i*IO_BE_W +: IO_BE_W],
                       wdata: req_wdata[i*IO_DATA_W +: IO_DATA_W]};
  end

  io_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid       (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .found_c     (found_c)
  );

  assign req_ready      = (state_q == IDLE) ? grant_c : '0;
  assign io_address     = bus_q.addr;
  assign io_byte_enable = bus_q.be;
  assign io_rw          = bus_q.rw;
  assign io_write_data  = bus_q.wdata;
  assign io_bus_enable  = en_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    own_d       = own_q;
    bus_d       = bus_q;
    en_d        = en_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          bus_d   = reqs[grant_idx_c];
          en_d    = 1'b1;
          ptr_d   = grant_idx_c;
          own_d   = grant_c;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Acknowledge takes priority over an expiring timeout.
        if (io_acknowledge) begin
          rsp_rdata_d = bus_q.rw ? io_read_data : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = own_q;
          en_d        = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = own_q;
          en_d        = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      own_q     <= '0;
      bus_q     <= '0;
      en_q      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      bus_q     <= bus_d;
      en_q      <= en_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: vector table, corner-case
// sequences and a randomized run against a transaction-timeline model.
module tb_io_bus_arbiter;

  localparam int NR = 3;
  localparam int TO = 4;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b1;
  always #5 clk_clk = ~clk_clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_rw;
  logic [15:0]      a_arr [NR];
  logic [1:0]       be_arr [NR];
  logic [15:0]      w_arr [NR];
  logic [NR*16-1:0] req_addr;
  logic [NR*2-1:0]  req_be;
  logic [NR*16-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [15:0]      rsp_rdata;
  logic             rsp_err;
  logic             busy;
  logic [15:0]      io_address;
  logic             io_bus_enable;
  logic [1:0]       io_byte_enable;
  logic             io_rw;
  logic [15:0]      io_write_data;
  logic             io_acknowledge;
  logic [15:0]      io_read_data;

  assign req_addr  = {a_arr[2], a_arr[1], a_arr[0]};
  assign req_be    = {be_arr[2], be_arr[1], be_arr[0]};
  assign req_wdata = {w_arr[2], w_arr[1], w_arr[0]};

  io_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .req_valid      (req_valid),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_be         (req_be),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .io_address     (io_address),
    .io_bus_enable  (io_bus_enable),
    .io_byte_enable (io_byte_enable),
    .io_rw          (io_rw),
    .io_write_data  (io_write_data),
    .io_acknowledge (io_acknowledge),
    .io_read_data   (io_read_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic set_reqs(input logic [NR-1:0] v, input logic rw, input logic [15:0] base,
                          input logic [1:0] be, input logic [15:0] wd);
    req_valid = v;
    req_rw    = rw ? '1 : '0;
    for (int i = 0; i < NR; i++) begin
      a_arr[i]  = base + 16'(i);
      be_arr[i] = be;
      w_arr[i]  = wd;
    end
  endtask

  task automatic do_reset();
    set_reqs('0, 1'b0, 16'h0, 2'b00, 16'h0);
    io_acknowledge = 1'b0;
    io_read_data   = 16'h0;
    reset_reset_n  = 1'b0;
    step();
    step();
    reset_reset_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          rw;
    logic [15:0]   base;
    logic [1:0]    be;
    logic [15:0]   wdata;
    int            ack_dly;   // 0 = never acknowledge
    logic [15:0]   rdata;
    int            exp_grant;
    logic [15:0]   exp_addr;
    int            exp_en;
    logic [15:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t tbl [7];

  // Single transaction from an idle arbiter, checked against one table row.
  task automatic run_txn(input vec_t v);
    logic [NR-1:0] eg;
    int k;
    eg = NR'(1) << v.exp_grant;
    set_reqs(v.valid, v.rw, v.base, v.be, v.wdata);
    #1;
    chk("tbl_ready", 32'(req_ready), 32'(eg));
    step();
    set_reqs('0, ~v.rw, 16'hFFFF, ~v.be, ~v.wdata);
    k = 0;
    while (io_bus_enable === 1'b1 && k < 20) begin
      k++;
      io_acknowledge = (k == v.ack_dly);
      io_read_data   = v.rdata;
      chk("tbl_addr", 32'(io_address), 32'(v.exp_addr));
      chk("tbl_rw", 32'(io_rw), 32'(v.rw));
      chk("tbl_be", 32'(io_byte_enable), 32'(v.be));
      chk("tbl_wdata", 32'(io_write_data), 32'(v.wdata));
      chk("tbl_busy_bus", 32'(busy), 32'd1);
      step();
    end
    io_acknowledge = 1'b0;
    io_read_data   = 16'hDEAD;
    chk("tbl_en_cycles", 32'(k), 32'(v.exp_en));
    chk("tbl_rsp_valid", 32'(rsp_valid), 32'(eg));
    chk("tbl_rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("tbl_rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("tbl_busy_resp", 32'(busy), 32'd1);
    step();
    chk("tbl_rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("tbl_busy_idle", 32'(busy), 32'd0);
    chk("tbl_rdata_hold", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("tbl_en_low", 32'(io_bus_enable), 32'd0);
  endtask

  // Randomized traffic against a timeline model: an accept at cycle t with
  // acknowledge delay d occupies the bus for L = min(d, TO) cycles, responds
  // at t+L+1 and frees the arbiter at t+L+2.
  task automatic random_phase(input int ncyc);
    logic [NR-1:0] rv, exp_ready, win_oh;
    logic          have, in_bus, in_rsp, m_rw, hold_err;
    int            t_acc, d, len, ptr_m, win;
    logic [15:0]   m_addr, m_wdata, hold_rd;
    logic [1:0]    m_be;
    do_reset();
    have = 1'b0; ptr_m = NR - 1; hold_rd = 16'h0; hold_err = 1'b0;
    t_acc = 0; d = 0; len = 0; win_oh = '0;
    m_rw = 1'b0; m_addr = 16'h0; m_wdata = 16'h0; m_be = 2'b00;
    for (int c = 0; c < ncyc; c++) begin
      if (have && c > t_acc + len + 1) have = 1'b0;
      in_bus = have && c >= t_acc + 1 && c <= t_acc + len;
      in_rsp = have && c == t_acc + len + 1;
      rv = NR'($urandom_range(0, (1 << NR) - 1));
      req_valid = rv;
      req_rw    = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        a_arr[i]  = 16'($urandom);
        be_arr[i] = 2'($urandom);
        w_arr[i]  = 16'($urandom);
      end
      io_acknowledge = in_bus ? (c == t_acc + d) : ($urandom_range(0, 2) == 0);
      io_read_data   = 16'($urandom);
      win = -1;
      if (!have) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (ptr_m + k) % NR;
          if (win < 0 && ((rv >> j) & NR'(1)) != '0) win = j;
        end
      end
      exp_ready = (win >= 0) ? (NR'(1) << win) : '0;
      #1;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_en", 32'(io_bus_enable), 32'(in_bus));
      chk("rnd_busy", 32'(busy), 32'(have));
      chk("rnd_rsp_valid", 32'(rsp_valid), in_rsp ? 32'(win_oh) : 32'd0);
      chk("rnd_rsp_rdata", 32'(rsp_rdata), 32'(hold_rd));
      chk("rnd_rsp_err", 32'(rsp_err), 32'(hold_err));
      if (in_bus) begin
        chk("rnd_addr", 32'(io_address), 32'(m_addr));
        chk("rnd_rw", 32'(io_rw), 32'(m_rw));
        chk("rnd_be", 32'(io_byte_enable), 32'(m_be));
        chk("rnd_wdata", 32'(io_write_data), 32'(m_wdata));
      end
      if (in_bus && c == t_acc + len) begin
        hold_rd  = (d <= TO && m_rw) ? io_read_data : 16'h0;
        hold_err = (d > TO);
      end
      if (win >= 0) begin
        have = 1'b1; t_acc = c; ptr_m = win; win_oh = exp_ready;
        d = $urandom_range(1, 6);
        len = (d <= TO) ? d : TO;
        m_rw = req_rw[win]; m_addr = a_arr[win]; m_be = be_arr[win]; m_wdata = w_arr[win];
      end
      step();
    end
  endtask

  initial begin
    int grants [4];
    int gcount, last, b2b;
    logic prev_en;

    tbl[0] = '{3'b001, 1'b1, 16'h0040, 2'b11, 16'h0000, 3, 16'hBEEF, 0, 16'h0040, 3, 16'hBEEF, 1'b0};
    tbl[1] = '{3'b010, 1'b0, 16'h0007, 2'b01, 16'h1234, 2, 16'h5555, 1, 16'h0008, 2, 16'h0000, 1'b0};
    tbl[2] = '{3'b111, 1'b1, 16'h0100, 2'b10, 16'h0000, 0, 16'h7777, 2, 16'h0102, 4, 16'h0000, 1'b1};
    tbl[3] = '{3'b011, 1'b1, 16'h0200, 2'b11, 16'h0000, 4, 16'hA5A5, 0, 16'h0200, 4, 16'hA5A5, 1'b0};
    tbl[4] = '{3'b101, 1'b1, 16'h0300, 2'b11, 16'h0000, 5, 16'h1111, 2, 16'h0302, 4, 16'h0000, 1'b1};
    tbl[5] = '{3'b110, 1'b0, 16'h0400, 2'b11, 16'hCAFE, 1, 16'h2222, 1, 16'h0401, 1, 16'h0000, 1'b0};
    tbl[6] = '{3'b100, 1'b1, 16'h0500, 2'b01, 16'h0000, 1, 16'h0F0F, 2, 16'h0502, 1, 16'h0F0F, 1'b0};

    // Reset state, asserted asynchronously between clock edges.
    set_reqs('0, 1'b0, 16'h0, 2'b00, 16'h0);
    io_acknowledge = 1'b0;
    io_read_data   = 16'h0;
    #2 reset_reset_n = 1'b0;
    #1;
    chk("rst_en", 32'(io_bus_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_io", {io_address, io_write_data}, 32'd0);
    chk("rst_io2", 32'({io_byte_enable, io_rw}), 32'd0);
    chk("rst_rsp", 32'({rsp_rdata, rsp_err}), 32'd0);
    step();
    step();
    reset_reset_n = 1'b1;
    #1;

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Contention: requesters 0 and 1 always valid, acknowledge on first bus cycle.
    do_reset();
    set_reqs(3'b011, 1'b1, 16'h0A00, 2'b11, 16'h0);
    gcount = 0; last = 0; b2b = 0; prev_en = 1'b0;
    for (int i = 0; i < 4; i++) grants[i] = -1;
    for (int c = 0; c < 14; c++) begin
      io_acknowledge = io_bus_enable;
      #1;
      if (req_ready != '0) begin
        for (int j = 0; j < NR; j++) if (req_ready == (NR'(1) << j)) last = j;
        if (gcount < 4) grants[gcount] = last;
        gcount++;
      end
      if (rsp_valid != '0) chk("cont_rsp_owner", 32'(rsp_valid), 32'(NR'(1) << last));
      if (io_bus_enable && prev_en) b2b++;
      prev_en = io_bus_enable;
      step();
    end
    io_acknowledge = 1'b0;
    chk("cont_g0", 32'(grants[0]), 32'd0);
    chk("cont_g1", 32'(grants[1]), 32'd1);
    chk("cont_g2", 32'(grants[2]), 32'd0);
    chk("cont_g3", 32'(grants[3]), 32'd1);
    chk("cont_en_gap", 32'(b2b), 32'd0);

    // Reset two cycles into BUS abandons the transaction.
    do_reset();
    set_reqs(3'b001, 1'b1, 16'h0C00, 2'b11, 16'h0);
    #1;
    chk("rmb_ready", 32'(req_ready), 32'd1);
    step();
    set_reqs('0, 1'b0, 16'h0, 2'b00, 16'h0);
    step();
    chk("rmb_en_before", 32'(io_bus_enable), 32'd1);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("rmb_en", 32'(io_bus_enable), 32'd0);
    chk("rmb_busy", 32'(busy), 32'd0);
    chk("rmb_rsp", 32'(rsp_valid), 32'd0);
    step();
    reset_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rmb_no_rsp", 32'({rsp_valid, busy}), 32'd0);
    end
    set_reqs(3'b111, 1'b1, 16'h0D00, 2'b11, 16'h0);
    #1;
    chk("rmb_first_grant", 32'(req_ready), 32'd1);

    // Acknowledge while idle is ignored.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      io_acknowledge = c[0];
      #1;
      chk("spur_state", 32'({busy, io_bus_enable}), 32'd0);
      chk("spur_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    io_acknowledge = 1'b0;

    random_phase(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
